// File: rtl/dot_product_pkg.sv
// Shared types and sizing helpers for the dot-product controller slice.
package dot_product_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFlush,
      StKick,
      StAccum,
      StDone
   } state_e;

   // Accumulator width that can hold VECTOR_WIDTH full-scale products without wrapping.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned vector_width);
      return 2 * data_width + $clog2(vector_width) + 1;
   endfunction

   localparam int unsigned DefDataWidth   = 8;
   localparam int unsigned DefVectorWidth = 4;
   localparam int unsigned DefAccWidth    = acc_width(DefDataWidth, DefVectorWidth);

   typedef logic [DefDataWidth-1:0] elem_t;
   typedef logic [DefAccWidth-1:0]  acc_t;

endpackage

// File: rtl/dp_mac_unit.sv
// Multiply-accumulate datapath: unsigned product, accumulator and saturating element count.
module dp_mac_unit
   import dot_product_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned VECTOR_WIDTH = 4,
   parameter int unsigned ACC_WIDTH    = acc_width(DATA_WIDTH, VECTOR_WIDTH),
   parameter int unsigned CNT_WIDTH    = $clog2(VECTOR_WIDTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  en_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [ACC_WIDTH-1:0]  acc_o,
   output logic [CNT_WIDTH-1:0]  elem_cnt_o,
   output logic                  full_o
);

   logic [ACC_WIDTH-1:0] acc_d, acc_q;
   logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
   logic                 full;
   logic                 take;

   assign full = (cnt_q == CNT_WIDTH'(VECTOR_WIDTH));
   // Elements past VECTOR_WIDTH are dropped so the sum never exceeds the sized range.
   assign take = en_i && !full;

   // Next-state for accumulator and element counter.
   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (take) begin
         acc_d = acc_q + ACC_WIDTH'(a_i) * ACC_WIDTH'(b_i);
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Accumulator and counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign acc_o      = acc_q;
   assign elem_cnt_o = cnt_q;
   assign full_o     = full;

endmodule

// File: rtl/dot_product_controller.sv
// Sequencer for the dot-product memory reader: host write forwarding, read kick-off,
// accumulation with watchdog, and a valid/ready result port.
module dot_product_controller
   import dot_product_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned VECTOR_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH     = 5,
   parameter int unsigned ACC_WIDTH      = acc_width(DATA_WIDTH, VECTOR_WIDTH),
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   input  logic                  host_wr_en,
   input  logic [ADDR_WIDTH-1:0] host_wr_addr,
   input  logic [DATA_WIDTH-1:0] host_data_a,
   input  logic [DATA_WIDTH-1:0] host_data_b,
   output logic                  host_wr_ready,
   output logic                  wr_err,
   output logic                  mem_write_en,
   output logic [ADDR_WIDTH-1:0] mem_write_addr,
   output logic [DATA_WIDTH-1:0] mem_data_a,
   output logic [DATA_WIDTH-1:0] mem_data_b,
   output logic                  mem_start_reading,
   input  logic                  mem_reading_done,
   input  logic [DATA_WIDTH-1:0] mem1_data,
   input  logic [DATA_WIDTH-1:0] mem2_data,
   input  logic                  mem_data_valid,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic                  count_err,
   output logic                  timeout_err
);

   localparam int unsigned CntWidth  = $clog2(VECTOR_WIDTH + 1);
   localparam int unsigned WdogWidth = $clog2(TIMEOUT_CYCLES + 1);

   state_e                state_d, state_q;
   logic [WdogWidth-1:0]  wdog_d, wdog_q;
   logic                  count_err_d, count_err_q;
   logic                  timeout_err_d, timeout_err_q;
   logic                  wr_err_d, wr_err_q;
   logic                  mem_write_en_d, mem_write_en_q;
   logic [ADDR_WIDTH-1:0] mem_write_addr_d, mem_write_addr_q;
   logic [DATA_WIDTH-1:0] mem_data_a_d, mem_data_a_q;
   logic [DATA_WIDTH-1:0] mem_data_b_d, mem_data_b_q;

   logic                  mac_clear;
   logic                  valid_acc;
   logic                  mac_full;
   logic [CntWidth-1:0]   elem_cnt;
   logic [CntWidth-1:0]   cnt_next;
   logic [ACC_WIDTH-1:0]  acc;

   assign valid_acc = (state_q == StAccum) && mem_data_valid;
   // Count as it will be after this cycle, so a valid coincident with done is included.
   assign cnt_next  = elem_cnt + CntWidth'(valid_acc && !mac_full);

   dp_mac_unit #(
      .DATA_WIDTH  (DATA_WIDTH),
      .VECTOR_WIDTH(VECTOR_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH),
      .CNT_WIDTH   (CntWidth)
   ) u_mac (
      .clk_i     (clk),
      .rst_i     (rst),
      .clear_i   (mac_clear),
      .en_i      (valid_acc),
      .a_i       (mem1_data),
      .b_i       (mem2_data),
      .acc_o     (acc),
      .elem_cnt_o(elem_cnt),
      .full_o    (mac_full)
   );

   // FSM next-state, watchdog and sticky error flags.
   always_comb begin
      state_d       = state_q;
      wdog_d        = wdog_q;
      count_err_d   = count_err_q;
      timeout_err_d = timeout_err_q;
      mac_clear     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d       = StFlush;
               mac_clear     = 1'b1;
               wdog_d        = '0;
               count_err_d   = 1'b0;
               timeout_err_d = 1'b0;
            end
         end
         StFlush: state_d = StKick;
         StKick:  state_d = StAccum;
         StAccum: begin
            wdog_d = valid_acc ? '0 : wdog_q + WdogWidth'(1);
            if (valid_acc && mac_full) begin
               count_err_d = 1'b1;
            end
            if (mem_reading_done) begin
               state_d = StDone;
               if (cnt_next != CntWidth'(VECTOR_WIDTH)) begin
                  count_err_d = 1'b1;
               end
            end else if (!mem_data_valid && (wdog_q == WdogWidth'(TIMEOUT_CYCLES - 1))) begin
               state_d       = StDone;
               timeout_err_d = 1'b1;
            end
         end
         StDone: begin
            if (result_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Host writes pass through only while idle; otherwise they are dropped and flagged.
   always_comb begin
      mem_write_en_d   = 1'b0;
      mem_write_addr_d = mem_write_addr_q;
      mem_data_a_d     = mem_data_a_q;
      mem_data_b_d     = mem_data_b_q;
      wr_err_d         = host_wr_en && (state_q != StIdle);
      if (host_wr_en && (state_q == StIdle)) begin
         mem_write_en_d   = 1'b1;
         mem_write_addr_d = host_wr_addr;
         mem_data_a_d     = host_data_a;
         mem_data_b_d     = host_data_b;
      end
   end

   // Control and write-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= StIdle;
         wdog_q           <= '0;
         count_err_q      <= 1'b0;
         timeout_err_q    <= 1'b0;
         wr_err_q         <= 1'b0;
         mem_write_en_q   <= 1'b0;
         mem_write_addr_q <= '0;
         mem_data_a_q     <= '0;
         mem_data_b_q     <= '0;
      end else begin
         state_q          <= state_d;
         wdog_q           <= wdog_d;
         count_err_q      <= count_err_d;
         timeout_err_q    <= timeout_err_d;
         wr_err_q         <= wr_err_d;
         mem_write_en_q   <= mem_write_en_d;
         mem_write_addr_q <= mem_write_addr_d;
         mem_data_a_q     <= mem_data_a_d;
         mem_data_b_q     <= mem_data_b_d;
      end
   end

   assign busy              = (state_q != StIdle);
   assign host_wr_ready     = (state_q == StIdle);
   assign mem_start_reading = (state_q == StKick);
   assign result_valid      = (state_q == StDone);
   assign result            = acc;
   assign count_err         = count_err_q;
   assign timeout_err       = timeout_err_q;
   assign wr_err            = wr_err_q;
   assign mem_write_en      = mem_write_en_q;
   assign mem_write_addr    = mem_write_addr_q;
   assign mem_data_a        = mem_data_a_q;
   assign mem_data_b        = mem_data_b_q;

endmodule

// File: tb/tb_dot_product_controller.sv
// Self-checking bench for dot_product_controller with a behavioural memory/reader model.
module tb_dot_product_controller;

   localparam int DW = 8;
   localparam int AW = 5;
   localparam int RW = 19;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy;
   logic          host_wr_en = 1'b0;
   logic [AW-1:0] host_wr_addr = '0;
   logic [DW-1:0] host_data_a = '0;
   logic [DW-1:0] host_data_b = '0;
   logic          host_wr_ready;
   logic          wr_err;
   logic          mem_write_en;
   logic [AW-1:0] mem_write_addr;
   logic [DW-1:0] mem_data_a;
   logic [DW-1:0] mem_data_b;
   logic          mem_start_reading;
   logic          mem_reading_done = 1'b0;
   logic [DW-1:0] mem1_data = '0;
   logic [DW-1:0] mem2_data = '0;
   logic          mem_data_valid = 1'b0;
   logic [RW-1:0] result;
   logic          result_valid;
   logic          result_ready = 1'b0;
   logic          count_err;
   logic          timeout_err;

   int checks = 0;
   int passed = 0;

   logic [7:0] va [4];
   logic [7:0] vb [4];
   logic [7:0] mem_a [32];
   logic [7:0] mem_b [32];
   int         kick_cnt = 0;

   dot_product_controller dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .busy             (busy),
      .host_wr_en       (host_wr_en),
      .host_wr_addr     (host_wr_addr),
      .host_data_a      (host_data_a),
      .host_data_b      (host_data_b),
      .host_wr_ready    (host_wr_ready),
      .wr_err           (wr_err),
      .mem_write_en     (mem_write_en),
      .mem_write_addr   (mem_write_addr),
      .mem_data_a       (mem_data_a),
      .mem_data_b       (mem_data_b),
      .mem_start_reading(mem_start_reading),
      .mem_reading_done (mem_reading_done),
      .mem1_data        (mem1_data),
      .mem2_data        (mem2_data),
      .mem_data_valid   (mem_data_valid),
      .result           (result),
      .result_valid     (result_valid),
      .result_ready     (result_ready),
      .count_err        (count_err),
      .timeout_err      (timeout_err)
   );

   always #5 clk = ~clk;

   // Vector memory behind the write port, and a tally of read kicks.
   always @(posedge clk) begin
      if (mem_write_en) begin
         mem_a[mem_write_addr] <= mem_data_a;
         mem_b[mem_write_addr] <= mem_data_b;
      end
      if (mem_start_reading) kick_cnt <= kick_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: dot product of the first min(n, 4) element pairs.
   function automatic int model_sum(input int n);
      int s = 0;
      for (int i = 0; i < 4 && i < n; i++) s += int'(va[i]) * int'(vb[i]);
      return s;
   endfunction

   task automatic write_vectors();
      for (int i = 0; i < 4; i++) begin
         host_wr_en   = 1'b1;
         host_wr_addr = AW'(i);
         host_data_a  = va[i];
         host_data_b  = vb[i];
         tick();
      end
      host_wr_en = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_kick();
      for (int i = 0; i < 8; i++) begin
         if (mem_start_reading) break;
         tick();
      end
   endtask

   // Reader model: nv valid beats from memory, then done (or done on the last beat).
   task automatic feed(input int nv, input bit coincident);
      for (int i = 0; i < nv; i++) begin
         mem_data_valid   = 1'b1;
         mem1_data        = (i < 4) ? mem_a[i] : 8'($urandom);
         mem2_data        = (i < 4) ? mem_b[i] : 8'($urandom);
         mem_reading_done = coincident && (i == nv - 1);
         tick();
      end
      mem_data_valid   = 1'b0;
      mem_reading_done = 1'b0;
      if (!coincident || nv == 0) begin
         mem_reading_done = 1'b1;
         tick();
         mem_reading_done = 1'b0;
      end
   endtask

   task automatic run_basic(input int nv, input bit coincident);
      write_vectors();
      start_run();
      wait_kick();
      tick();
      feed(nv, coincident);
   endtask

   task automatic accept();
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
   endtask

   task automatic set_ref_vectors();
      for (int i = 0; i < 4; i++) begin
         va[i] = 8'(i + 1);
         vb[i] = 8'(i + 5);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, wr_err, mem_write_en, mem_start_reading, result_valid, count_err, timeout_err}
          !== 7'b0)
         $display("FAIL reset_flags got %b want 0", {busy, wr_err, mem_write_en,
                  mem_start_reading, result_valid, count_err, timeout_err});
      else passed++;
      checks++;
      if (result !== '0) $display("FAIL reset_result got %0d want 0", result);
      else passed++;
      checks++;
      if (host_wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", host_wr_ready);
      else passed++;
   endtask

   task automatic test_basic();
      set_ref_vectors();
      host_wr_en = 1'b1; host_wr_addr = 5'd3; host_data_a = 8'd4; host_data_b = 8'd8;
      tick();
      host_wr_en = 1'b0;
      checks++;
      if ({mem_write_en, mem_write_addr, mem_data_a, mem_data_b} !== {1'b1, 5'd3, 8'd4, 8'd8})
         $display("FAIL fwd_write got %b/%0d/%0d/%0d want 1/3/4/8",
                  mem_write_en, mem_write_addr, mem_data_a, mem_data_b);
      else passed++;
      write_vectors();
      start_run();
      checks++;
      if ({busy, mem_start_reading} !== 2'b10)
         $display("FAIL kick_t1 got busy=%b kick=%b want 1/0", busy, mem_start_reading);
      else passed++;
      tick();
      checks++;
      if (mem_start_reading !== 1'b1) $display("FAIL kick_t2 got %b want 1", mem_start_reading);
      else passed++;
      tick();
      feed(4, 1'b0);
      checks++;
      if (result_valid !== 1'b1 || result !== RW'(70))
         $display("FAIL basic_result got v=%b %0d want v=1 70", result_valid, result);
      else passed++;
      checks++;
      if ({count_err, timeout_err} !== 2'b00)
         $display("FAIL basic_errs got %b want 00", {count_err, timeout_err});
      else passed++;
      accept();
      checks++;
      if ({result_valid, busy} !== 2'b00)
         $display("FAIL basic_release got v=%b busy=%b want 0/0", result_valid, busy);
      else passed++;
   endtask

   task automatic test_max();
      for (int i = 0; i < 4; i++) begin va[i] = 8'hff; vb[i] = 8'hff; end
      run_basic(4, 1'b0);
      checks++;
      if (result !== RW'(260100)) $display("FAIL max_result got %0d want 260100", result);
      else passed++;
      accept();
   endtask

   task automatic test_hold();
      int k0;
      set_ref_vectors();
      run_basic(4, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (result_valid !== 1'b1 || result !== RW'(70))
            $display("FAIL hold_c%0d got v=%b %0d want v=1 70", i, result_valid, result);
         else passed++;
         tick();
      end
      accept();
      k0 = kick_cnt;
      start_run();
      tick();
      checks++;
      if (mem_start_reading !== 1'b1)
         $display("FAIL b2b_kick got %b want 1", mem_start_reading);
      else passed++;
      tick();
      feed(4, 1'b0);
      accept();
      tick();
      checks++;
      if (kick_cnt - k0 !== 1) $display("FAIL b2b_kicks got %0d want 1", kick_cnt - k0);
      else passed++;
   endtask

   task automatic test_busy_drop();
      int k0;
      for (int i = 0; i < 4; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
      write_vectors();
      k0 = kick_cnt;
      start_run();
      host_wr_en = 1'b1; host_wr_addr = 5'd0; host_data_a = ~va[0]; start = 1'b1;
      tick();
      host_wr_en = 1'b0; start = 1'b0;
      checks++;
      if ({wr_err, mem_write_en} !== 2'b10)
         $display("FAIL drop_pulse got wr_err=%b we=%b want 1/0", wr_err, mem_write_en);
      else passed++;
      tick();
      checks++;
      if (wr_err !== 1'b0) $display("FAIL drop_pulse_end got %b want 0", wr_err);
      else passed++;
      feed(4, 1'b0);
      checks++;
      if (result !== RW'(model_sum(4)))
         $display("FAIL drop_result got %0d want %0d", result, model_sum(4));
      else passed++;
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      accept();
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (kick_cnt - k0 !== 1 || busy !== 1'b0)
         $display("FAIL drop_kicks got %0d busy=%b want 1 busy=0", kick_cnt - k0, busy);
      else passed++;
   endtask

   task automatic test_timeout();
      int cyc;
      for (int i = 0; i < 4; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
      write_vectors();
      start_run();
      wait_kick();
      tick();
      for (int i = 0; i < 2; i++) begin
         mem_data_valid = 1'b1; mem1_data = mem_a[i]; mem2_data = mem_b[i];
         tick();
      end
      mem_data_valid = 1'b0;
      cyc = 0;
      while (!result_valid && cyc < 100) begin
         tick();
         cyc++;
      end
      checks++;
      if (cyc !== 64) $display("FAIL timeout_cycles got %0d want 64", cyc);
      else passed++;
      checks++;
      if (timeout_err !== 1'b1) $display("FAIL timeout_flag got %b want 1", timeout_err);
      else passed++;
      checks++;
      if (result !== RW'(model_sum(2)))
         $display("FAIL timeout_partial got %0d want %0d", result, model_sum(2));
      else passed++;
      accept();
   endtask

   task automatic test_mid_reset();
      int k0;
      set_ref_vectors();
      write_vectors();
      start_run();
      wait_kick();
      tick();
      mem_data_valid = 1'b1; mem1_data = mem_a[0]; mem2_data = mem_b[0];
      tick();
      mem_data_valid = 1'b0;
      k0 = kick_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({busy, result_valid, mem_start_reading, wr_err, count_err, timeout_err} !== 6'b0
          || result !== '0)
         $display("FAIL midrst_outputs got flags=%b result=%0d want 0/0", {busy, result_valid,
                  mem_start_reading, wr_err, count_err, timeout_err}, result);
      else passed++;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (kick_cnt !== k0) $display("FAIL midrst_nokick got %0d want %0d", kick_cnt, k0);
      else passed++;
      run_basic(4, 1'b0);
      checks++;
      if (result !== RW'(70) || {count_err, timeout_err} !== 2'b00)
         $display("FAIL midrst_rerun got %0d errs=%b want 70 errs=00", result,
                  {count_err, timeout_err});
      else passed++;
      accept();
   endtask

   task automatic test_count_and_coincident();
      set_ref_vectors();
      run_basic(3, 1'b0);
      checks++;
      if (count_err !== 1'b1 || result !== RW'(model_sum(3)))
         $display("FAIL short_count got cerr=%b %0d want 1 %0d", count_err, result,
                  model_sum(3));
      else passed++;
      accept();
      run_basic(4, 1'b1);
      checks++;
      if (count_err !== 1'b0 || result !== RW'(70))
         $display("FAIL coincident got cerr=%b %0d want 0 70", count_err, result);
      else passed++;
      accept();
   endtask

   task automatic test_random();
      int nv;
      bit co;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
         nv = 3 + int'($urandom_range(0, 2));
         co = 1'($urandom_range(0, 1));
         run_basic(nv, co);
         checks++;
         if (result_valid !== 1'b1 || result !== RW'(model_sum(nv))
             || count_err !== (nv != 4) || timeout_err !== 1'b0)
            $display("FAIL rand%0d nv=%0d co=%0d got v=%b %0d cerr=%b terr=%b want 1 %0d %0d 0",
                     r, nv, co, result_valid, result, count_err, timeout_err, model_sum(nv),
                     nv != 4);
         else passed++;
         accept();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_hold();
      test_busy_drop();
      test_timeout();
      test_mid_reset();
      test_count_and_coincident();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
